carrier_mixer_iq: RTL and testbench
===================================

Name: carrier_mixer_iq

Overview:
- Parametrised IQ carrier mixer for the QAM transmitter.
- Accepts one (I,Q) symbol per valid/ready handshake and holds it for SPS output samples.
- A free-running phase counter indexes a 2^PHASE_W-entry cos/sin table; each sample is s = I*cos - Q*sin, rounded, scaled and saturated.
- Sits between the symbol mapper/pulse shaper and the DAC interface; supports output backpressure.

Parameters:
- DATA_W, 16, signed width of I, Q and the output sample
- COEF_W, 12, signed carrier coefficient width; full scale = 2^(COEF_W-1)-1
- PHASE_W, 4, log2 of phases per carrier period (16 phases)
- SPS, 16, output samples per symbol (>=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_i  in  DATA_W  signed I component
- in_q  in  DATA_W  signed Q component
- in_valid  in  1  symbol valid
- in_ready  out  1  block can accept a symbol this cycle
- out_data  out  DATA_W  signed passband sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_first  out  1  marks sample 0 of each symbol, aligned with out_data

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n. All registers clear on reset: out_data=0, out_valid=0, out_first=0, in_ready=0 during reset and 1 on the first cycle after, state=IDLE, phase=0, sample count=0.
- Global pipeline enable en = !out_valid || out_ready. When en=0, every register holds: state, counters and pipeline.
- FSM IDLE:
  - in_ready=1.
  - On in_valid, latch I/Q, clear phase and sample count, go to RUN.
- FSM RUN:
  - Each en cycle issues one sample at the current phase, then phase++ (wraps mod 2^PHASE_W) and count++.
  - On the issue with count==SPS-1:
    - If in_valid && en, latch the new symbol (in_ready=1 that cycle), reset count to 0 and keep phase continuous; no bubble.
    - Otherwise return to IDLE.
  - in_ready=0 in all other RUN cycles.
- Pipeline, 3 stages, latency 3 enabled edges from issue to out_valid:
  - S0: table lookup registers cos[p], sin[p] and I, Q, plus the first flag.
  - S1: products I*cos and Q*sin, full width DATA_W+COEF_W.
  - S2: difference (DATA_W+COEF_W+1 bits), add 2^(COEF_W-2), arithmetic shift right by COEF_W-1, saturate to DATA_W, register the result.
- Accept-to-first-output: a symbol accepted at edge t gives out_valid=1 with out_first=1 after edge t+3, assuming no stall.
- Table values: cos[k] = round(cos(2*pi*k/2^PHASE_W) * (2^(COEF_W-1)-1)); sin[k] = cos[(k - 2^(PHASE_W-2)) mod 2^PHASE_W].
- Boundary cases:
  - Phase wrap 15->0 is seamless.
  - A stall on the last sample delays in_ready until that sample issues.
  - Reset mid-symbol drops the symbol and all in-flight samples.

Optional Feature:
- Macro CARRIER_SAT_EN.
- Defined: S2 clamps the result to [-(2^(DATA_W-1)), 2^(DATA_W-1)-1].
- Undefined: S2 truncates to the low DATA_W bits (two's-complement wrap), saving comparators.

Decomposition:
- Package qam_tx_pkg holds:
  - function cos_coef(k, PHASE_W, COEF_W) returning a signed COEF_W value;
  - localparams QTR = 2^(PHASE_W-2) and RND = 2^(COEF_W-2);
  - FSM state enum {IDLE, RUN}.
- Sub-module carrier_lut_rom (params PHASE_W, COEF_W): phase in, registered cos/sin out; it implements S0.

Test Plan:
- I=1000, Q=0, SPS=16 -> out_data at phases 0/4/8/12 = 1000/0/-1000/0; out_first only on phase 0; 16 samples then in_ready=1.
- I=0, Q=1000 -> phase 4 gives -1000, phase 12 gives +1000, phase 0 gives 0.
- Two symbols back-to-back with in_valid held -> 32 contiguous out_valid cycles; phase continues 0..15,0..15; second out_first at sample 16.
- I=32767, Q=-32767, phase 2 (cos=sin=1447):
  - With CARRIER_SAT_EN, out=32767.
  - Without it, out=-19233.
- out_ready toggled randomly, 50% -> no sample lost or duplicated; sequence matches the unstalled golden model; out_data stable while out_valid && !out_ready.
- rst_n pulled low at sample 7 of a symbol -> out_valid=0 immediately (async); after release in_ready=1; the next symbol restarts at phase 0.

Source files
------------

// File: rtl/qam_tx_pkg.sv
// +------------------------------------------------------------------------+
// | qam_tx_pkg : shared types, constants and carrier-table generator for   |
// |              the QAM transmitter datapath.                             |
// | Revision   : 1.0                                                       |
// +------------------------------------------------------------------------+
`default_nettype none

package qam_tx_pkg;

   localparam int PHASE_W_DEF = 4;
   localparam int COEF_W_DEF  = 12;
   localparam int QTR         = 2 ** (PHASE_W_DEF - 2);
   localparam int RND         = 2 ** (COEF_W_DEF - 2);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam longint PI_Q30 = 64'sd3373259426;

   // round(cos(2*pi*k/2^phase_w) * (2^(coef_w-1)-1)); integer Taylor series
   // on a first-quadrant angle so it folds to a constant at elaboration.
   function automatic logic signed [31:0] cos_coef(input int k, input int phase_w,
                                                   input int coef_w);
      longint n, quarter, quad, j, x, x2, term, acc, full, mag;
      n       = longint'(1) << phase_w;
      quarter = n >> 2;
      quad    = (longint'(k) % n) / quarter;
      j       = longint'(k) % quarter;
      if (quad == 1 || quad == 3)
         j = quarter - j;
      x    = (2 * PI_Q30 * j) / n;
      x2   = (x * x) >>> 30;
      term = longint'(1) << 30;
      acc  = term;
      for (int t = 1; t <= 8; t++) begin
         term = -(((term * x2) >>> 30) / longint'((2 * t - 1) * (2 * t)));
         acc  = acc + term;
      end
      full = (longint'(1) << (coef_w - 1)) - 1;
      mag  = (acc * full + (longint'(1) << 29)) >>> 30;
      if (quad == 1 || quad == 2)
         mag = -mag;
      return 32'(mag);
   endfunction

endpackage

`default_nettype wire

// File: rtl/carrier_lut_rom.sv
// +------------------------------------------------------------------------+
// | carrier_lut_rom : registered cos/sin carrier lookup (pipeline S0).     |
// | Revision        : 1.0                                                  |
// +------------------------------------------------------------------------+
`default_nettype none

module carrier_lut_rom
   import qam_tx_pkg::*;
#(
   parameter int PHASE_W = 4,
   parameter int COEF_W  = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [PHASE_W-1:0]       phase,
   output logic signed [COEF_W-1:0] cos_out,
   output logic signed [COEF_W-1:0] sin_out
);

   localparam int                 N     = 2 ** PHASE_W;
   localparam logic [PHASE_W-1:0] QTR_L = PHASE_W'(N / 4);

   logic signed [COEF_W-1:0] cos_tab [N];
   logic [PHASE_W-1:0]       sin_idx;

   for (genvar g = 0; g < N; g++) begin : g_tab
      localparam logic signed [31:0] C = cos_coef(g, PHASE_W, COEF_W);
      assign cos_tab[g] = C[COEF_W-1:0];
   end

   // sin is cos a quarter period late; the index subtraction wraps mod N
   assign sin_idx = phase - QTR_L;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cos_out <= '0;
         sin_out <= '0;
      end else if (en) begin
         cos_out <= cos_tab[phase];
         sin_out <= cos_tab[sin_idx];
      end
   end

endmodule

`default_nettype wire

// File: rtl/carrier_mixer_iq.sv
// +------------------------------------------------------------------------+
// | carrier_mixer_iq : IQ carrier mixer, s = I*cos - Q*sin, SPS samples    |
// |                    per symbol. Define CARRIER_SAT_EN to saturate.      |
// | Revision         : 1.0                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module carrier_mixer_iq
   import qam_tx_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int COEF_W  = 12,
   parameter int PHASE_W = 4,
   parameter int SPS     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] in_i,
   input  logic signed [DATA_W-1:0] in_q,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_first
);

   localparam int                       CNT_W  = $clog2(SPS);
   localparam int                       PROD_W = DATA_W + COEF_W;
   localparam int                       SUM_W  = PROD_W + 1;
   localparam logic [CNT_W-1:0]         LAST   = CNT_W'(SPS - 1);
   localparam logic signed [SUM_W-1:0]  RND_L  = SUM_W'(2 ** (COEF_W - 2));
   localparam logic signed [DATA_W-1:0] RES_HI = {1'b0, {(DATA_W - 1){1'b1}}};
   localparam logic signed [DATA_W-1:0] RES_LO = {1'b1, {(DATA_W - 1){1'b0}}};

   state_t                   state, state_nx;
   logic signed [DATA_W-1:0] sym_i, sym_q, sym_i_nx, sym_q_nx;
   logic [PHASE_W-1:0]       phase, phase_nx;
   logic [CNT_W-1:0]         count, count_nx;
   logic                     en, issue, ready_c;

   assign en    = !out_valid || out_ready;
   assign issue = en && (state == RUN);

   always_comb begin
      state_nx = state;
      sym_i_nx = sym_i;
      sym_q_nx = sym_q;
      phase_nx = phase;
      count_nx = count;
      ready_c  = 1'b0;
      case (state)
         IDLE: begin
            ready_c = en;
            if (in_valid && en) begin
               sym_i_nx = in_i;
               sym_q_nx = in_q;
               phase_nx = '0;
               count_nx = '0;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (en) begin
               phase_nx = phase + 1'b1;
               count_nx = count + 1'b1;
               if (count == LAST) begin
                  // next symbol rides straight in; phase stays continuous
                  ready_c  = 1'b1;
                  count_nx = '0;
                  if (in_valid) begin
                     sym_i_nx = in_i;
                     sym_q_nx = in_q;
                  end else begin
                     state_nx = IDLE;
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign in_ready = rst_n && ready_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sym_i <= '0;
         sym_q <= '0;
         phase <= '0;
         count <= '0;
      end else begin
         state <= state_nx;
         sym_i <= sym_i_nx;
         sym_q <= sym_q_nx;
         phase <= phase_nx;
         count <= count_nx;
      end
   end

   logic signed [COEF_W-1:0] cos_v, sin_v;
   logic signed [DATA_W-1:0] s0_i, s0_q;
   logic                     s0_valid, s0_first;

   carrier_lut_rom #(
      .PHASE_W (PHASE_W),
      .COEF_W  (COEF_W)
   ) u_lut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .phase   (phase),
      .cos_out (cos_v),
      .sin_out (sin_v)
   );

   logic signed [PROD_W-1:0] prod_i, prod_q;
   logic                     s1_valid, s1_first;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_i     <= '0;
         s0_q     <= '0;
         s0_valid <= 1'b0;
         s0_first <= 1'b0;
         prod_i   <= '0;
         prod_q   <= '0;
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
      end else if (en) begin
         s0_i     <= sym_i;
         s0_q     <= sym_q;
         s0_valid <= issue;
         s0_first <= issue && (count == '0);
         prod_i   <= s0_i * cos_v;
         prod_q   <= s0_q * sin_v;
         s1_valid <= s0_valid;
         s1_first <= s0_first;
      end
   end

   logic signed [SUM_W-1:0]  diff, sum;
   logic signed [DATA_W+1:0] shifted;
   logic signed [DATA_W-1:0] result;
   logic                     unused_bits;

   always_comb begin
      diff    = {prod_i[PROD_W-1], prod_i} - {prod_q[PROD_W-1], prod_q};
      sum     = diff + RND_L;
      shifted = sum[SUM_W-1:COEF_W-1];
      result  = shifted[DATA_W-1:0];
`ifdef CARRIER_SAT_EN
      if (shifted > RES_HI)
         result = RES_HI;
      else if (shifted < RES_LO)
         result = RES_LO;
`endif
   end

`ifdef CARRIER_SAT_EN
   assign unused_bits = ^sum[COEF_W-2:0];
`else
   assign unused_bits = ^{sum[COEF_W-2:0], shifted[DATA_W+1:DATA_W], RES_HI, RES_LO};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
      end else if (en) begin
         out_data  <= result;
         out_valid <= s1_valid;
         out_first <= s1_first;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_carrier_mixer_iq.sv
// +------------------------------------------------------------------------+
// | tb_carrier_mixer_iq : directed self-checking bench for the IQ mixer.   |
// | Revision            : 1.0                                              |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_carrier_mixer_iq;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic signed [15:0] in_i = '0;
   logic signed [15:0] in_q = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] out_data;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic               out_first;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   int cos_t [16] = '{2047, 1891, 1447, 783, 0, -783, -1447, -1891,
                      -2047, -1891, -1447, -783, 0, 783, 1447, 1891};

   typedef struct {
      int data;
      bit first;
      int cyc;
   } smp_t;

   smp_t got[$];

   carrier_mixer_iq #(
      .DATA_W  (16),
      .COEF_W  (12),
      .PHASE_W (4),
      .SPS     (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_i      (in_i),
      .in_q      (in_q),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_first (out_first)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      smp_t s;
      if (rst_n && out_valid && out_ready) begin
         s.data  = int'(out_data);
         s.first = out_first;
         s.cyc   = cyc;
         got.push_back(s);
      end
   end

   function automatic int model(input int i, input int q, input int p);
      longint             v;
      logic signed [15:0] w;
      v = longint'(i) * cos_t[p] - longint'(q) * cos_t[(p + 12) % 16] + 1024;
      v = v >>> 11;
`ifdef CARRIER_SAT_EN
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
`endif
      w = 16'(v);
      return int'(w);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int i, input int q);
      bit done = 1'b0;
      in_i     = 16'(i);
      in_q     = 16'(q);
      in_valid = 1'b1;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         tick();
      end
      n_vec++;
      if (!done) begin
         n_err++;
         $display("FAIL send_accept: symbol (%0d,%0d) not accepted, want accept within 300 cycles", i, q);
      end
   endtask

   task automatic wait_samples(input int n, input int budget);
      int k = 0;
      while (got.size() < n && k < budget) begin
         tick();
         k++;
      end
      n_vec++;
      if (got.size() < n) begin
         n_err++;
         $display("FAIL sample_wait: got %0d samples, want %0d", got.size(), n);
      end
   endtask

   task automatic test_reset();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      #1 rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec += 4;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      if (out_first !== 1'b0) begin n_err++; $display("FAIL rst_out_first: got %b want 0", out_first); end
      if (out_data !== 16'sd0) begin n_err++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
      tick();
   endtask

   task automatic test_cos();
      int first_hi = 0;
      int spot [4] = '{1000, 0, -1000, 0};
      got.delete();
      send(1000, 0);
      in_valid = 1'b0;
      for (int k = 1; k <= 24 && first_hi == 0; k++) begin
         @(negedge clk);
         if (in_ready) first_hi = k;
         tick();
      end
      n_vec++;
      if (first_hi != 16) begin n_err++; $display("FAIL cos_ready_cycle: got %0d want 16", first_hi); end
      wait_samples(16, 40);
      repeat (5) tick();
      n_vec++;
      if (got.size() != 16) begin n_err++; $display("FAIL cos_count: got %0d want 16", got.size()); end
      if (got.size() >= 16) begin
         for (int k = 0; k < 16; k++) begin
            n_vec += 2;
            if (got[k].data != model(1000, 0, k)) begin
               n_err++; $display("FAIL cos_data[%0d]: got %0d want %0d", k, got[k].data, model(1000, 0, k));
            end
            if (got[k].first != (k == 0)) begin
               n_err++; $display("FAIL cos_first[%0d]: got %b want %b", k, got[k].first, (k == 0));
            end
         end
         for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (got[4 * k].data != spot[k]) begin
               n_err++; $display("FAIL cos_spot[%0d]: got %0d want %0d", 4 * k, got[4 * k].data, spot[k]);
            end
         end
      end
   endtask

   task automatic test_sin();
      got.delete();
      send(0, 1000);
      in_valid = 1'b0;
      wait_samples(16, 40);
      repeat (4) tick();
      n_vec++;
      if (got.size() != 16) begin n_err++; $display("FAIL sin_count: got %0d want 16", got.size()); end
      if (got.size() >= 16) begin
         n_vec += 3;
         if (got[0].data != 0) begin n_err++; $display("FAIL sin_ph0: got %0d want 0", got[0].data); end
         if (got[4].data != -1000) begin n_err++; $display("FAIL sin_ph4: got %0d want -1000", got[4].data); end
         if (got[12].data != 1000) begin n_err++; $display("FAIL sin_ph12: got %0d want 1000", got[12].data); end
         for (int k = 0; k < 16; k++) begin
            n_vec++;
            if (got[k].data != model(0, 1000, k)) begin
               n_err++; $display("FAIL sin_data[%0d]: got %0d want %0d", k, got[k].data, model(0, 1000, k));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int ei, eq;
      got.delete();
      send(500, -300);
      send(-700, 200);
      in_valid = 1'b0;
      wait_samples(32, 80);
      repeat (4) tick();
      n_vec++;
      if (got.size() != 32) begin n_err++; $display("FAIL b2b_count: got %0d want 32", got.size()); end
      if (got.size() >= 32) begin
         for (int k = 0; k < 32; k++) begin
            ei = (k < 16) ? 500 : -700;
            eq = (k < 16) ? -300 : 200;
            n_vec += 3;
            if (got[k].data != model(ei, eq, k % 16)) begin
               n_err++; $display("FAIL b2b_data[%0d]: got %0d want %0d", k, got[k].data, model(ei, eq, k % 16));
            end
            if (got[k].first != (k % 16 == 0)) begin
               n_err++; $display("FAIL b2b_first[%0d]: got %b want %b", k, got[k].first, (k % 16 == 0));
            end
            if (got[k].cyc != got[0].cyc + k) begin
               n_err++; $display("FAIL b2b_gap[%0d]: got cycle %0d want %0d", k, got[k].cyc, got[0].cyc + k);
            end
         end
      end
   endtask

   task automatic test_saturation();
      int want2;
`ifdef CARRIER_SAT_EN
      want2 = 32767;
`else
      want2 = -19233;
`endif
      got.delete();
      send(32767, -32767);
      in_valid = 1'b0;
      wait_samples(16, 40);
      repeat (4) tick();
      n_vec++;
      if (got.size() != 16) begin n_err++; $display("FAIL sat_count: got %0d want 16", got.size()); end
      if (got.size() >= 16) begin
         n_vec++;
         if (got[2].data != want2) begin n_err++; $display("FAIL sat_ph2: got %0d want %0d", got[2].data, want2); end
         for (int k = 0; k < 16; k++) begin
            n_vec++;
            if (got[k].data != model(32767, -32767, k)) begin
               n_err++; $display("FAIL sat_data[%0d]: got %0d want %0d", k, got[k].data, model(32767, -32767, k));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int ei, eq;
      got.delete();
      fork
         begin
            send(1234, -567);
            send(-2000, 3000);
            in_valid = 1'b0;
         end
         begin
            bit                 stall = 1'b0;
            logic signed [15:0] held  = '0;
            for (int k = 0; k < 600 && got.size() < 32; k++) begin
               @(negedge clk);
               if (stall) begin
                  n_vec++;
                  if (out_valid !== 1'b1 || out_data !== held) begin
                     n_err++;
                     $display("FAIL bp_hold: got valid=%b data=%0d want valid=1 data=%0d", out_valid, out_data, held);
                  end
               end
               stall = out_valid && !out_ready;
               held  = out_data;
               tick();
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      wait_samples(32, 40);
      repeat (4) tick();
      n_vec++;
      if (got.size() != 32) begin n_err++; $display("FAIL bp_count: got %0d want 32", got.size()); end
      if (got.size() >= 32) begin
         for (int k = 0; k < 32; k++) begin
            ei = (k < 16) ? 1234 : -2000;
            eq = (k < 16) ? -567 : 3000;
            n_vec += 2;
            if (got[k].data != model(ei, eq, k % 16)) begin
               n_err++; $display("FAIL bp_data[%0d]: got %0d want %0d", k, got[k].data, model(ei, eq, k % 16));
            end
            if (got[k].first != (k % 16 == 0)) begin
               n_err++; $display("FAIL bp_first[%0d]: got %b want %b", k, got[k].first, (k % 16 == 0));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      got.delete();
      out_ready = 1'b1;
      send(1000, 0);
      in_valid = 1'b0;
      wait_samples(7, 40);
      #2 rst_n = 1'b0;
      #1;
      n_vec += 2;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b want 0", in_ready); end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_release_ready: got %b want 1", in_ready); end
      tick();
      got.delete();
      send(0, 1000);
      in_valid = 1'b0;
      wait_samples(16, 40);
      repeat (6) tick();
      n_vec++;
      if (got.size() != 16) begin n_err++; $display("FAIL midrst_count: got %0d want 16", got.size()); end
      if (got.size() >= 16) begin
         for (int k = 0; k < 16; k++) begin
            n_vec += 2;
            if (got[k].data != model(0, 1000, k)) begin
               n_err++; $display("FAIL midrst_data[%0d]: got %0d want %0d", k, got[k].data, model(0, 1000, k));
            end
            if (got[k].first != (k == 0)) begin
               n_err++; $display("FAIL midrst_first[%0d]: got %b want %b", k, got[k].first, (k == 0));
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_cos();
      test_sin();
      test_back_to_back();
      test_saturation();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
